// File: rtl/micro_core_p.sv
// Parametrised accumulator core: program loaded over a valid/ready port, then
// runs a 3-cycle FETCH/DECODE/EXECUTE loop with a hardware call stack and HALT.
module micro_core_p #(
  parameter int DW     = 8,
  parameter int PAW    = 8,
  parameter int DAW    = 4,
  parameter int SDEPTH = 4
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            ld_valid,
  output logic            ld_ready,
  input  logic [DW+3:0]   ld_data,
  input  logic            ld_last,
  output logic            halted,
  output logic            stk_err,
  output logic [PAW-1:0]  pc,
  output logic [DW-1:0]   acc,
  output logic [3:0]      flags
);
  localparam int IW  = DW + 4;
  localparam int SPW = $clog2(SDEPTH + 1);

  typedef enum logic [2:0] {S_LOAD, S_FETCH, S_DECODE, S_EXEC, S_HALT} state_t;

  state_t          state_reg;
  logic [PAW-1:0]  pc_reg, load_addr_reg;
  logic [DW-1:0]   acc_reg, dr_reg;
  logic [3:0]      flags_reg;
  logic [SPW-1:0]  sp_reg;
  logic            stk_err_reg;
  logic [IW-1:0]   ir_reg;

  logic [IW-1:0]   pmem  [2**PAW];
  logic [DW-1:0]   dmem  [2**DAW];
  // Stack is sized to the full sp range so sp indexes it without truncation.
  logic [PAW-1:0]  stack [2**SPW];

  logic [3:0]      op;
  logic [DW-1:0]   k, rhs, alu_res;
  logic [DW:0]     sum;
  logic            alu_c, alu_o, jmp_take, stk_full, stk_empty;
  logic [PAW-1:0]  pc_inc;

  assign op        = ir_reg[IW-1 -: 4];
  assign k         = ir_reg[DW-1:0];
  assign pc_inc    = pc_reg + PAW'(1);
  assign stk_full  = (sp_reg == SPW'(SDEPTH));
  assign stk_empty = (sp_reg == '0);

  assign ld_ready = (state_reg == S_LOAD);
  assign halted   = (state_reg == S_HALT);
  assign stk_err  = stk_err_reg;
  assign pc       = pc_reg;
  assign acc      = acc_reg;
  assign flags    = flags_reg;

  always_comb begin
    rhs     = (op == 4'hE) ? k : dr_reg;
    sum     = '0;
    alu_res = '0;
    alu_c   = 1'b0;
    alu_o   = 1'b0;
    case (op)
      4'hC, 4'hE: begin
        sum     = {1'b0, acc_reg} + {1'b0, rhs};
        alu_res = sum[DW-1:0];
        alu_c   = sum[DW];
        alu_o   = (acc_reg[DW-1] == rhs[DW-1]) && (alu_res[DW-1] != acc_reg[DW-1]);
      end
      4'hD: begin
        alu_res = acc_reg - rhs;
        alu_c   = (acc_reg >= rhs);
        alu_o   = (acc_reg[DW-1] != rhs[DW-1]) && (alu_res[DW-1] != acc_reg[DW-1]);
      end
      4'hF: alu_res = acc_reg ^ rhs;
      default: ;
    endcase
  end

  always_comb begin
    jmp_take = 1'b0;
    case (op)
      4'h3: jmp_take = flags_reg[3];
      4'h4: jmp_take = flags_reg[2];
      4'h5: jmp_take = flags_reg[1];
      4'h6: jmp_take = flags_reg[0];
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_reg     <= S_LOAD;
      pc_reg        <= '0;
      acc_reg       <= '0;
      flags_reg     <= '0;
      sp_reg        <= '0;
      load_addr_reg <= '0;
      stk_err_reg   <= 1'b0;
    end else begin
      case (state_reg)
        S_LOAD: begin
          if (ld_valid) begin
            load_addr_reg <= load_addr_reg + PAW'(1);
            if (ld_last || load_addr_reg == '1) begin
              state_reg     <= S_FETCH;
              pc_reg        <= '0;
              acc_reg       <= '0;
              flags_reg     <= '0;
              sp_reg        <= '0;
              load_addr_reg <= '0;
            end
          end
        end
        S_FETCH:  state_reg <= S_DECODE;
        S_DECODE: state_reg <= S_EXEC;
        S_EXEC: begin
          state_reg <= S_FETCH;
          pc_reg    <= pc_inc;
          case (op)
            4'h1: begin
              state_reg <= S_HALT;
              pc_reg    <= pc_reg;
            end
            4'h2: pc_reg <= k[PAW-1:0];
            4'h3, 4'h4, 4'h5, 4'h6: if (jmp_take) pc_reg <= k[PAW-1:0];
            4'h7: begin
              if (stk_full) begin
                stk_err_reg <= 1'b1;
                state_reg   <= S_HALT;
                pc_reg      <= pc_reg;
              end else begin
                sp_reg <= sp_reg + SPW'(1);
                pc_reg <= k[PAW-1:0];
              end
            end
            4'h8: begin
              if (stk_empty) begin
                stk_err_reg <= 1'b1;
                state_reg   <= S_HALT;
                pc_reg      <= pc_reg;
              end else begin
                sp_reg <= sp_reg - SPW'(1);
                pc_reg <= stack[sp_reg - SPW'(1)];
              end
            end
            4'h9: acc_reg <= k;
            4'hA: acc_reg <= dr_reg;
            4'hC, 4'hD, 4'hE, 4'hF: begin
              acc_reg   <= alu_res;
              flags_reg <= {(alu_res == '0), alu_c, alu_res[DW-1], alu_o};
            end
            default: ;
          endcase
        end
        default: state_reg <= S_HALT;
      endcase
    end
  end

  // Memories and pipeline registers carry no reset.
  always_ff @(posedge clk) begin
    if (rst && state_reg == S_LOAD && ld_valid)
      pmem[load_addr_reg] <= ld_data;
    if (state_reg == S_FETCH)
      ir_reg <= pmem[pc_reg];
    if (state_reg == S_DECODE)
      dr_reg <= dmem[ir_reg[DAW-1:0]];
    if (rst && state_reg == S_EXEC && op == 4'hB)
      dmem[k[DAW-1:0]] <= acc_reg;
    if (rst && state_reg == S_EXEC && op == 4'h7 && !stk_full)
      stack[sp_reg] <= pc_inc;
  end

endmodule

// File: doc/micro_core_p.md
Name: micro_core_p

Overview:
Parametrised successor to the 8-bit FETCH/DECODE/EXECUTE accumulator microcontroller, with configurable data width and memory depths.
- Program memory is filled through an external valid/ready load port. There is no file-based init.
- Adds a hardware call/return stack, a HALT instruction, stack-error detection and observation outputs.
- Sits as the CPU core of the FPGA top level. Program and data memories are internal.

Parameters:
DW, 8, data/accumulator width; instruction width IW = DW+4
PAW, 8, program address width; PMem depth 2**PAW; PAW <= DW required
DAW, 4, data address width; DMem depth 2**DAW; DAW <= DW required
SDEPTH, 4, call-stack entries (>=1)

Ports:
clk  in  1  clock
rst  in  1  asynchronous, active-low reset
ld_valid  in  1  load word valid
ld_ready  out  1  core accepts load word (=1 only in LOAD)
ld_data  in  IW  instruction word to load
ld_last  in  1  marks final load word
halted  out  1  core in HALT state
stk_err  out  1  sticky: stack overflow/underflow caused halt
pc  out  PAW  program counter
acc  out  DW  accumulator
flags  out  4  {Z,C,S,O}

Behaviour:
- Reset (rst=0, async):
  - state=LOAD; pc=0, acc=0, flags=0, sp=0, load_addr=0.
  - halted=0, stk_err=0, ld_ready=1 once state settles.
  - Memories are not reset.
- States: LOAD, FETCH, DECODE, EXECUTE, HALT. One instruction takes exactly 3 cycles (FETCH→DECODE→EXECUTE→FETCH).
- LOAD:
  - On ld_valid&ld_ready: PMem[load_addr]<=ld_data, load_addr++.
  - Ends on ld_last, or when the accepted word was at address 2**PAW-1.
  - On exit: →FETCH, pc=0, acc=0, flags=0, sp=0, load_addr=0.
  - ld_valid=0 stalls indefinitely with no state change.
- FETCH: IR<=PMem[pc].
- DECODE: DR<=DMem[IR[DAW-1:0]] (combinational read).
- EXECUTE: update per opcode; pc<=pc+1 modulo 2**PAW unless stated otherwise.
- Instruction fields: op=IR[IW-1:IW-4], k=IR[DW-1:0].
- Opcodes:
  - 0 NOP.
  - 1 HALT: →HALT, pc unchanged.
  - 2 JMP: pc<=k[PAW-1:0].
  - 3 JZ / 4 JC / 5 JS / 6 JO: jump to k if flag=1, else pc+1.
  - 7 CALL: stack[sp]<=pc+1, sp++, pc<=k.
  - 8 RET: sp--, pc<=stack[sp-1].
  - 9 LDI: acc<=k.
  - A LD: acc<=DR.
  - B ST: DMem[k[DAW-1:0]]<=acc on the EXECUTE edge.
  - C ADD: acc<=acc+DR.
  - D SUB: acc<=acc-DR.
  - E ADDI: acc<=acc+k.
  - F XOR: acc<=acc^DR.
- Flags: updated only by C/D/E/F; all other ops leave flags unchanged.
  - Z: result==0.
  - S: result MSB.
  - C for ADD/ADDI: carry out of DW bits.
  - C for SUB: 1 iff acc>=DR unsigned (no borrow).
  - O: signed overflow (two's complement).
  - XOR: C=0, O=0.
- Stack errors:
  - CALL with sp==SDEPTH, or RET with sp==0: no pc/sp change, stk_err<=1, →HALT.
- HALT: all registers frozen. halted=1 combinationally from state. Exit only via reset.
- Write into the same DMem address that is read in the next instruction's DECODE: the new value is read (3-cycle spacing guarantees this).
- Reset mid-load or mid-instruction: immediate return to the reset state. A new program load is required; PMem contents beyond the new load are stale but unreachable only if the program avoids them.

Test Plan:
- Load 4 words with ld_valid gapped (1,0,1,1,0,1; ld_last on 4th) → exactly 4 writes, ld_ready drops the cycle after last, FETCH begins with pc=0.
- Program LDI 0x7F (0x97F), ADDI 0x01 (0xE01), HALT (0x100) → acc=0x80, flags Z0 C0 S1 O1, halted=1 nine cycles after FETCH entry, pc=2.
- LDI 0x05, ST 3, LDI 0x05, SUB 3, JZ 0x10 → acc=0, Z=1, C=1, pc=0x10; repeat with second LDI 0x04 → C=0, S=1, pc falls through to 5.
- SDEPTH=4, recursive CALL to self → 4 pushes succeed, 5th CALL sets stk_err=1, halted=1, pc = CALL address; separate test with RET at sp=0 → stk_err=1.
- Nested CALL 0x20 / CALL 0x30 / RET / RET → pc returns to 0x21, then to caller+1; sp back to 0.
- Assert rst=0 during EXECUTE of ADD → outputs clear asynchronously within the same cycle, state=LOAD, ld_ready=1 after release; the reload runs correctly.
